// File: rtl/item_pkg.sv
// Shared types and helpers for the item sequencer.
//   item_t       : 3-bit item codes understood by the HEX word decoder
//   seq_state_t  : sequencer FSM states
//   is_valid_item: true for the six codes the decoder can display
//   next_item    : auto/manual advance order, wrapping APPLE back to PEN
package item_pkg;

    typedef enum logic [2:0] {
        PEN     = 3'b000,
        GLASSES = 3'b001,
        BOTTLE  = 3'b011,
        CUP     = 3'b100,
        SPOON   = 3'b101,
        APPLE   = 3'b110
    } item_t;

    typedef enum logic {
        SHOW,
        BLANK
    } seq_state_t;

    function automatic logic is_valid_item(input item_t item);
        logic valid;
        case (item)
            PEN, GLASSES, BOTTLE, CUP, SPOON, APPLE: valid = 1'b1;
            default:                                 valid = 1'b0;
        endcase
        return valid;
    endfunction

    // Undefined codes fall back to PEN so the decoder is always driven legally.
    function automatic item_t next_item(input item_t item);
        item_t nxt;
        case (item)
            PEN:     nxt = GLASSES;
            GLASSES: nxt = BOTTLE;
            BOTTLE:  nxt = CUP;
            CUP:     nxt = SPOON;
            SPOON:   nxt = APPLE;
            default: nxt = PEN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector with a registered history bit.
//   clk_i   : system clock
//   reset_i : asynchronous active-high reset, clears history
//   sig_i   : synchronized level input
//   rise_o  : high in the cycle where sig_i is 1 and was 0 on the previous cycle
module edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/item_sequencer.sv
// Item code sequencer for the six-word HEX decoder.
//   clk_i       : system clock
//   reset_i     : asynchronous active-high reset
//   tick_i      : one-cycle timebase enable
//   auto_en_i   : 1 = advance automatically when the dwell expires
//   step_i      : key level, acted on at its rising edge
//   sel_valid_i : direct-select strobe
//   sel_code_i  : requested item code, sampled with sel_valid_i
//   bcd_o       : current item code (never 3'b010 or 3'b111)
//   blank_o     : 1 while the display is in its blank gap
//   wrap_o      : one-cycle pulse when the sequence wraps APPLE -> PEN
//   err_o       : one-cycle pulse on a direct select of an undefined code
module item_sequencer
    import item_pkg::*;
#(
    parameter int unsigned DWELL_TICKS = 8,
    parameter int unsigned BLANK_TICKS = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_i,
    input  logic       auto_en_i,
    input  logic       step_i,
    input  logic       sel_valid_i,
    input  logic [2:0] sel_code_i,
    output logic [2:0] bcd_o,
    output logic       blank_o,
    output logic       wrap_o,
    output logic       err_o
);

    localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_TICKS - 1);
    localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    item_t            bcd_q, bcd_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic  step_rise;
    item_t sel_item;
    logic  sel_ok;

    edge_detect u_step_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (step_i),
        .rise_o  (step_rise)
    );

    assign sel_item = item_t'(sel_code_i);
    assign sel_ok   = sel_valid_i & is_valid_item(sel_item);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        wrap_d  = 1'b0;
        // An invalid select only flags; the rest of the cycle proceeds normally.
        err_d   = sel_valid_i & ~is_valid_item(sel_item);

        if (sel_ok) begin
            // Valid select overrides everything, including a same-cycle step.
            bcd_d   = sel_item;
            state_d = SHOW;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SHOW: begin
                    if (step_rise) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end else if (auto_en_i && tick_i) begin
                        if (cnt_q == DwellLast) begin
                            state_d = BLANK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end
                end
                BLANK: begin
                    // Step presses are dropped here; the gap runs out even in manual mode.
                    if (tick_i) begin
                        if (cnt_q == BlankLast) begin
                            state_d = SHOW;
                            cnt_d   = '0;
                            bcd_d   = next_item(bcd_q);
                            wrap_d  = (bcd_q == APPLE);
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end
                end
                default: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            bcd_q   <= PEN;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bcd_o   = bcd_q;
    assign blank_o = (state_q == BLANK);
    assign wrap_o  = wrap_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_item_sequencer.sv
// Self-checking bench for item_sequencer (DWELL_TICKS=4, BLANK_TICKS=2).
module tb_item_sequencer;

    typedef struct packed {
        logic [2:0] bcd;
        logic       blank;
        logic       wrap;
        logic       err;
    } out_t;

    typedef struct {
        logic       tick;
        logic       auto_en;
        logic       step;
        logic       sel_valid;
        logic [2:0] sel_code;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, auto_en, step, sel_valid;
    logic [2:0] sel_code;
    logic [2:0] bcd;
    logic       blank, wrap, err;

    int   n_checks = 0;
    int   n_errors = 0;
    out_t exp_q[$];
    vec_t tbl[6];

    item_sequencer #(
        .DWELL_TICKS (4),
        .BLANK_TICKS (2),
        .CNT_W       (8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .tick_i      (tick),
        .auto_en_i   (auto_en),
        .step_i      (step),
        .sel_valid_i (sel_valid),
        .sel_code_i  (sel_code),
        .bcd_o       (bcd),
        .blank_o     (blank),
        .wrap_o      (wrap),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input out_t act, input out_t want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got bcd=%b blank=%b wrap=%b err=%b, want bcd=%b blank=%b wrap=%b err=%b",
                     name, act.bcd, act.blank, act.wrap, act.err,
                     want.bcd, want.blank, want.wrap, want.err);
        end
    endtask

    // Drive one cycle of inputs, queue its expected result, sample just after the edge.
    task automatic run_cycle(input logic tk, input logic au, input logic st, input logic sv,
                             input logic [2:0] sc, input out_t e, input string name);
        out_t got;
        out_t want;
        tick      = tk;
        auto_en   = au;
        step      = st;
        sel_valid = sv;
        sel_code  = sc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {bcd, blank, wrap, err};
        want = exp_q.pop_front();
        check(name, got, want);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < 6; i++) begin
            run_cycle(tbl[i].tick, tbl[i].auto_en, tbl[i].step, tbl[i].sel_valid,
                      tbl[i].sel_code, tbl[i].exp, name);
        end
    endtask

    initial begin
        logic [2:0] ord[6];
        logic [2:0] cur, nxt;

        // Reset release with auto run: 3 more SHOW cycles, 2 BLANK, then GLASSES.
        for (int i = 0; i < 6; i++) begin
            tbl[i].tick      = 1'b1;
            tbl[i].auto_en   = 1'b1;
            tbl[i].step      = 1'b0;
            tbl[i].sel_valid = 1'b0;
            tbl[i].sel_code  = 3'b000;
        end
        tbl[0].exp = '{bcd: 3'b000, blank: 1'b0, wrap: 1'b0, err: 1'b0};
        tbl[1].exp = '{bcd: 3'b000, blank: 1'b0, wrap: 1'b0, err: 1'b0};
        tbl[2].exp = '{bcd: 3'b000, blank: 1'b0, wrap: 1'b0, err: 1'b0};
        tbl[3].exp = '{bcd: 3'b000, blank: 1'b1, wrap: 1'b0, err: 1'b0};
        tbl[4].exp = '{bcd: 3'b000, blank: 1'b1, wrap: 1'b0, err: 1'b0};
        tbl[5].exp = '{bcd: 3'b001, blank: 1'b0, wrap: 1'b0, err: 1'b0};

        ord[0] = 3'b000; ord[1] = 3'b001; ord[2] = 3'b011;
        ord[3] = 3'b100; ord[4] = 3'b101; ord[5] = 3'b110;

        reset = 1'b1; tick = 1'b0; auto_en = 1'b0; step = 1'b0;
        sel_valid = 1'b0; sel_code = 3'b000;
        #12;
        check("reset_state", {bcd, blank, wrap, err}, 6'b000_0_0_0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: first dwell out of reset
        run_table("reset_release");

        // 2: auto run through the remaining items and the wrap
        for (int i = 1; i < 6; i++) begin
            cur = ord[i];
            nxt = ord[(i + 1) % 6];
            for (int k = 0; k < 3; k++) run_cycle(1, 1, 0, 0, 3'b000, {cur, 3'b000}, "auto_show");
            for (int k = 0; k < 2; k++) run_cycle(1, 1, 0, 0, 3'b000, {cur, 3'b100}, "auto_blank");
            run_cycle(1, 1, 0, 0, 3'b000, {nxt, 1'b0, (nxt == 3'b000), 1'b0}, "auto_advance");
        end
        run_cycle(1, 1, 0, 0, 3'b000, 6'b000_0_0_0, "wrap_one_cycle");

        // 3: manual step held for 3 cycles from BOTTLE gives one advance
        run_cycle(0, 0, 0, 1, 3'b011, 6'b011_0_0_0, "sel_bottle");
        run_cycle(1, 0, 1, 0, 3'b000, 6'b011_1_0_0, "step_rise_blank");
        run_cycle(1, 0, 1, 0, 3'b000, 6'b011_1_0_0, "step_held_blank");
        run_cycle(1, 0, 1, 0, 3'b000, 6'b100_0_0_0, "step_advance_cup");
        run_cycle(1, 0, 0, 0, 3'b000, 6'b100_0_0_0, "manual_hold_1");
        run_cycle(1, 0, 0, 0, 3'b000, 6'b100_0_0_0, "manual_hold_2");

        // 4: direct select during BLANK with a same-cycle step, then invalid selects
        run_cycle(0, 0, 1, 0, 3'b000, 6'b100_1_0_0, "enter_blank");
        run_cycle(0, 0, 0, 0, 3'b000, 6'b100_1_0_0, "blank_no_tick");
        run_cycle(1, 0, 1, 1, 3'b101, 6'b101_0_0_0, "sel_over_step");
        run_cycle(1, 0, 1, 0, 3'b000, 6'b101_0_0_0, "no_extra_advance");
        run_cycle(1, 0, 0, 1, 3'b111, 6'b101_0_0_1, "err_sel_111");
        run_cycle(1, 0, 0, 0, 3'b000, 6'b101_0_0_0, "err_one_cycle");
        run_cycle(0, 0, 1, 1, 3'b010, 6'b101_1_0_1, "err_with_step");
        run_cycle(1, 0, 0, 0, 3'b000, 6'b101_1_0_0, "blank_manual_1");
        run_cycle(1, 0, 0, 0, 3'b000, 6'b110_0_0_0, "blank_manual_done");

        // 5: sparse ticks, auto_en paused mid-dwell keeps the count
        run_cycle(0, 1, 0, 1, 3'b001, 6'b001_0_0_0, "sel_glasses");
        for (int c = 0; c < 6; c++)
            run_cycle(logic'(c % 3 == 2), 1, 0, 0, 3'b000, 6'b001_0_0_0, "sparse_auto");
        for (int c = 0; c < 10; c++)
            run_cycle(logic'(c % 3 == 2), 0, 0, 0, 3'b000, 6'b001_0_0_0, "auto_paused");
        for (int c = 0; c < 5; c++)
            run_cycle(logic'(c % 3 == 2), 1, 0, 0, 3'b000, 6'b001_0_0_0, "auto_resumed");
        run_cycle(1, 1, 0, 0, 3'b000, 6'b001_1_0_0, "resume_to_blank");

        // 6: async reset in the middle of APPLE's blank gap
        run_cycle(1, 1, 0, 1, 3'b110, 6'b110_0_0_0, "sel_apple");
        for (int k = 0; k < 3; k++) run_cycle(1, 1, 0, 0, 3'b000, 6'b110_0_0_0, "apple_show");
        run_cycle(1, 1, 0, 0, 3'b000, 6'b110_1_0_0, "apple_blank");
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {bcd, blank, wrap, err}, 6'b000_0_0_0);
        @(posedge clk);
        #1;
        check("reset_held", {bcd, blank, wrap, err}, 6'b000_0_0_0);
        reset = 1'b0;
        run_table("post_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule

// File: doc/item_sequencer.md
Name: item_sequencer

Overview:
Sequences the 3-bit item code that drives the six-digit HEX word decoder (PEN, GLASSES, BOTTLE, CUP, SPOON, APPLE).
- Auto mode: steps through the six valid items with a timed dwell, then a blank gap.
- Manual mode: a key press advances the item; a switch-driven direct select can load any item.
- Guarantees the decoder never sees the undefined codes 3'b010 or 3'b111. Sits between the board key/switch/clock-divider logic and the decoder.

Parameters:
DWELL_TICKS, 8, number of tick pulses an item is shown in auto mode; legal range 1 to 2**CNT_W-1.
BLANK_TICKS, 2, number of tick pulses of blank gap between items; legal range 1 to 2**CNT_W-1.
CNT_W, 8, width of the shared tick counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; all state clears immediately on assertion
tick  in  1  one-cycle timebase enable from the clock divider
auto_en  in  1  1 = auto-advance on dwell expiry; 0 = manual only
step  in  1  synchronized, active-high key level; acted on at its rising edge
sel_valid  in  1  direct-select request strobe
sel_code  in  3  requested item code, sampled when sel_valid=1
bcd  out  3  current item code to the decoder
blank  out  1  1 = downstream forces all six digits to 7'b1111111
wrap  out  1  one-cycle pulse when bcd goes from 3'b110 to 3'b000
err  out  1  one-cycle pulse when sel_valid=1 with an invalid sel_code

Behaviour:
- All outputs are registered.
- Reset values: bcd=3'b000, blank=0, wrap=0, err=0, state=SHOW, cnt=0, edge-detect history=0.
- Item order: 000 -> 001 -> 011 -> 100 -> 101 -> 110 -> 000. The next-item function maps an invalid input to 000; this is unreachable by design.
- Step edge: step_rise = step & ~step_d1, where step_d1 is a registered copy of step.
- FSM states: SHOW and BLANK. blank=1 exactly while in BLANK; bcd holds the old item during BLANK.
- Priority within a cycle, highest first:
  - valid select
  - invalid-select err pulse, which does not block the lower items
  - step_rise
  - tick counting
- Valid select (sel_valid=1 and sel_code not 010/111), in any state: next cycle bcd=sel_code, state=SHOW, blank=0, cnt=0, wrap=0. Any step_rise in the same cycle is discarded.
- Invalid select: err=1 on the next cycle only; bcd, state and cnt are unaffected by the select, and normal step/tick processing applies that cycle.
- In SHOW:
  - step_rise (regardless of auto_en): next cycle state=BLANK, blank=1, cnt=0.
  - Else if auto_en=1 and tick=1:
    - cnt==DWELL_TICKS-1: go to BLANK, cnt=0.
    - Otherwise: cnt+1.
  - auto_en=0: cnt holds its value. It resumes from that value when auto_en returns to 1.
- In BLANK:
  - step_rise is ignored and dropped, not queued.
  - On tick: if cnt==BLANK_TICKS-1, go to SHOW with bcd=next(bcd), cnt=0, blank=0; otherwise cnt+1.
  - BLANK completes even if auto_en=0.
- wrap=1 for exactly the one cycle in which bcd first shows 000 after a 110 -> 000 advance. A direct select of 000 never raises wrap.
- Latency: step_rise in cycle N gives blank=1 in cycle N+1. The final BLANK tick in cycle M gives the new bcd with blank=0 in cycle M+1.
- tick and step_rise arriving together in SHOW: step wins and cnt clears.
- Reset asserted mid-operation (any state or count): outputs return to reset values asynchronously. After deassertion, operation starts in SHOW/PEN with a fresh dwell count.
- Counter arithmetic is unsigned CNT_W bits. Compares use the parameters truncated to CNT_W; the legal parameter range guarantees no overflow.

Decomposition:
- Package item_pkg holds:
  - typedef enum logic [2:0] item_t {PEN=3'b000, GLASSES=3'b001, BOTTLE=3'b011, CUP=3'b100, SPOON=3'b101, APPLE=3'b110}
  - function is_valid_item(item_t)
  - function next_item(item_t)
  - typedef enum logic {SHOW, BLANK} seq_state_t
- One sub-module, edge_detect (rising-edge, registered history, same clk/reset), used for step.
- The FSM, counter and output registers stay in item_sequencer.

Test Plan:
Bench settings: DWELL_TICKS=4, BLANK_TICKS=2, tick held at 1 unless stated.
1. Reset release with auto_en=1 -> bcd=000 and blank=0 for 4 cycles, blank=1 for 2 cycles, then bcd=001 with blank=0.
2. Auto run through six items -> bcd sequence 000,001,011,100,101,110,000, never 010 or 111. wrap=1 only on the first cycle of the second 000.
3. auto_en=0, step pulsed high for 3 cycles while bcd=011 -> blank=1 the next cycle; after 2 ticks bcd=100. Holding step produces only one advance.
4. sel_valid=1 with sel_code=101 during BLANK, plus step_rise in the same cycle -> next cycle bcd=101, blank=0, cnt=0, no extra advance. sel_code=111 -> err pulse of 1 cycle, bcd unchanged.
5. auto_en=1, tick asserted every 3rd cycle, auto_en dropped after 2 ticks and restored 10 cycles later -> 2 further ticks are needed before BLANK.
6. reset asserted asynchronously mid-BLANK with bcd=110 -> outputs go to 000/0/0/0 immediately without a clock edge. After release, normal dwell from PEN, with wrap=0.
